mure_block_builder: RTL and testbench

MURE_BLOCK_BUILDER -- requirements
Module: mure_block_builder

---
 rtl/mure_block_builder.sv | 183 ++++++++++++++++++
 tb/tb_mure_block_builder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mure_block_builder.sv
// Merges retired uops into basic blocks (base address, halfword count, priv) for the trace encoder.
// Latency: a block appears on valid_o one cycle after the uop that closes it. Optional idle flush: MURE_BLOCK_TIMEOUT_EN.
// Backpressure: ready_o drops while a closed block waits for the output register or the output is stalled.
module mure_block_builder #(
    parameter int IRETIRE_LEN    = 8,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int PRIV_LEN       = 2,
    parameter int CAUSE_LEN      = 5,
    parameter int XLEN           = 32,
    localparam int ITYPE_LEN     = 3,
    localparam int INST_LEN      = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [ITYPE_LEN-1:0]   itype_i,
    input  logic [INST_LEN-1:0]    iaddr_i,
    input  logic                   iretire_i,
    input  logic [1:0]             ilastsize_i,
    input  logic [PRIV_LEN-1:0]    priv_i,
    input  logic [CAUSE_LEN-1:0]   cause_i,
    input  logic [XLEN-1:0]        tval_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [ITYPE_LEN-1:0]   itype_o,
    output logic [INST_LEN-1:0]    iaddr_o,
    output logic [IRETIRE_LEN-1:0] iretire_o,
    output logic [1:0]             ilastsize_o,
    output logic [PRIV_LEN-1:0]    priv_o,
    output logic [CAUSE_LEN-1:0]   cause_o,
    output logic [XLEN-1:0]        tval_o
);

    localparam logic [ITYPE_LEN-1:0] IT_STD = 3'd0;
    localparam logic [ITYPE_LEN-1:0] IT_EXC = 3'd1;
    localparam logic [ITYPE_LEN-1:0] IT_INT = 3'd2;

    typedef struct packed {
        logic [ITYPE_LEN-1:0]   itype;
        logic [INST_LEN-1:0]    iaddr;
        logic [IRETIRE_LEN-1:0] iretire;
        logic [1:0]             ilastsize;
        logic [PRIV_LEN-1:0]    priv;
        logic [CAUSE_LEN-1:0]   cause;
        logic [XLEN-1:0]        tval;
    } blk_t;

    typedef enum logic [1:0] {S_EMPTY, S_OPEN, S_CLOSED} state_t;

    state_t state_q, state_d;
    blk_t   acc_q, acc_d;
    blk_t   out_q, out_d;
    logic   vld_q, vld_d;

    logic                   accept, out_free, is_std, noret;
    logic                   contig, join_ok, close_before, timeout;
    logic [IRETIRE_LEN:0]   inc, sum;
    logic [INST_LEN-1:0]    next_addr;
    blk_t                   std_blk, new_blk;

    assign out_free = !vld_q || ready_i;
    assign ready_o  = (state_q != S_CLOSED) && out_free;
    assign accept   = valid_i && ready_o;
    assign is_std   = (itype_i == IT_STD);
    // A trap that retired nothing never extends a block: it reports its own address.
    assign noret    = ((itype_i == IT_EXC) || (itype_i == IT_INT)) && !iretire_i;

    always_comb begin
        inc = '0;
        if (!noret) inc[ilastsize_i] = 1'b1;
    end

    assign sum          = {1'b0, acc_q.iretire} + inc;
    assign next_addr    = acc_q.iaddr + {{(INST_LEN-IRETIRE_LEN-1){1'b0}}, acc_q.iretire, 1'b0};
    assign contig       = (iaddr_i == next_addr);
    assign join_ok      = (state_q == S_OPEN) && contig && (priv_i == acc_q.priv) &&
                          !sum[IRETIRE_LEN] && !noret;
    assign close_before = (state_q == S_OPEN) && !join_ok;

    always_comb begin
        std_blk       = acc_q;
        std_blk.itype = IT_STD;
        std_blk.cause = '0;
        std_blk.tval  = '0;

        new_blk.itype     = itype_i;
        new_blk.iaddr     = iaddr_i;
        new_blk.iretire   = inc[IRETIRE_LEN-1:0];
        new_blk.ilastsize = noret ? 2'd0 : ilastsize_i;
        new_blk.priv      = priv_i;
        new_blk.cause     = cause_i;
        new_blk.tval      = tval_i;
    end

`ifdef MURE_BLOCK_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCW-1:0] tcnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tcnt_q <= '0;
        end else if (accept || (state_q != S_OPEN)) begin
            tcnt_q <= '0;
        end else if (tcnt_q != TCW'(TIMEOUT_CYCLES)) begin
            tcnt_q <= tcnt_q + 1'b1;
        end
    end

    assign timeout = (state_q == S_OPEN) && (tcnt_q == TCW'(TIMEOUT_CYCLES)) && out_free;
`else
    // No idle timer in this build; an open block waits for a real close condition.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        out_d   = out_q;
        vld_d   = vld_q && !ready_i;
        if (accept) begin
            if (join_ok && is_std) begin
                acc_d.iretire   = sum[IRETIRE_LEN-1:0];
                acc_d.ilastsize = ilastsize_i;
            end else if (join_ok) begin
                out_d           = new_blk;
                out_d.iaddr     = acc_q.iaddr;
                out_d.iretire   = sum[IRETIRE_LEN-1:0];
                out_d.ilastsize = ilastsize_i;
                vld_d           = 1'b1;
                state_d         = S_EMPTY;
            end else begin
                if (close_before) begin
                    out_d = std_blk;
                    vld_d = 1'b1;
                end
                acc_d = new_blk;
                if (is_std) begin
                    state_d = S_OPEN;
                end else if (close_before) begin
                    // Old block owns the output this cycle; the trap block waits in CLOSED.
                    state_d = S_CLOSED;
                end else begin
                    out_d   = new_blk;
                    vld_d   = 1'b1;
                    state_d = S_EMPTY;
                end
            end
        end else if ((state_q == S_CLOSED) && out_free) begin
            out_d   = acc_q;
            vld_d   = 1'b1;
            state_d = S_EMPTY;
        end else if (timeout) begin
            out_d   = std_blk;
            vld_d   = 1'b1;
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_EMPTY;
            acc_q   <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
        end
    end

    assign valid_o     = vld_q;
    assign itype_o     = out_q.itype;
    assign iaddr_o     = out_q.iaddr;
    assign iretire_o   = out_q.iretire;
    assign ilastsize_o = out_q.ilastsize;
    assign priv_o      = out_q.priv;
    assign cause_o     = out_q.cause;
    assign tval_o      = out_q.tval;

endmodule

// File: tb/tb_mure_block_builder.sv
// Bench for mure_block_builder (IRETIRE_LEN=4 so the count-overflow boundary is reachable).
// Expected blocks are queued when uops are driven and compared as the DUT hands them over.
module tb_mure_block_builder;

    localparam logic [2:0] STD = 3'd0, EXC = 3'd1, INT = 3'd2, ERET = 3'd3,
                           NTB = 3'd4, TB = 3'd5, UJ = 3'd6;

    typedef struct packed {
        logic [2:0]  itype;
        logic [31:0] iaddr;
        logic [3:0]  iretire;
        logic [1:0]  ls;
        logic [1:0]  priv;
        logic [4:0]  cause;
        logic [31:0] tval;
    } blk_t;

    typedef struct packed {
        logic [2:0]  itype;
        logic [31:0] iaddr;
        logic        ret;
        logic [1:0]  ls;
        logic [1:0]  priv;
        logic [4:0]  cause;
        logic [31:0] tval;
    } uop_t;

    typedef struct {
        uop_t u;
        int   n;
        blk_t e0;
        blk_t e1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, ready_o, iretire_i, valid_o, ready_i;
    logic [2:0]  itype_i, itype_o;
    logic [31:0] iaddr_i, iaddr_o, tval_i, tval_o;
    logic [1:0]  ilastsize_i, ilastsize_o, priv_i, priv_o;
    logic [4:0]  cause_i, cause_o;
    logic [3:0]  iretire_o;

    int   checks = 0;
    int   errors = 0;
    blk_t exp_q[$];
    vec_t tbl[$];
    blk_t mon_g, mon_e;

    always #5 clk = ~clk;

    mure_block_builder #(
        .IRETIRE_LEN(4), .TIMEOUT_CYCLES(16), .PRIV_LEN(2), .CAUSE_LEN(5), .XLEN(32)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .valid_i(valid_i), .ready_o(ready_o), .itype_i(itype_i), .iaddr_i(iaddr_i),
        .iretire_i(iretire_i), .ilastsize_i(ilastsize_i), .priv_i(priv_i),
        .cause_i(cause_i), .tval_i(tval_i),
        .valid_o(valid_o), .ready_i(ready_i), .itype_o(itype_o), .iaddr_o(iaddr_o),
        .iretire_o(iretire_o), .ilastsize_o(ilastsize_o), .priv_o(priv_o),
        .cause_o(cause_o), .tval_o(tval_o)
    );

    function automatic blk_t B(input logic [2:0] t, input logic [31:0] a, input logic [3:0] r,
                               input logic [1:0] ls, input logic [1:0] p,
                               input logic [4:0] c, input logic [31:0] v);
        blk_t b;
        b.itype = t; b.iaddr = a; b.iretire = r; b.ls = ls; b.priv = p; b.cause = c; b.tval = v;
        return b;
    endfunction

    function automatic uop_t U(input logic [2:0] t, input logic [31:0] a, input logic r,
                               input logic [1:0] ls, input logic [1:0] p,
                               input logic [4:0] c, input logic [31:0] v);
        uop_t u;
        u.itype = t; u.iaddr = a; u.ret = r; u.ls = ls; u.priv = p; u.cause = c; u.tval = v;
        return u;
    endfunction

    // STD blocks carry no trap payload, so only the common fields are compared for them.
    function automatic bit blk_match(input blk_t g, input blk_t e);
        if (g.itype != e.itype || g.iaddr != e.iaddr || g.iretire != e.iretire || g.priv != e.priv)
            return 1'b0;
        if (e.itype != STD && (g.ls != e.ls || g.cause != e.cause || g.tval != e.tval))
            return 1'b0;
        return 1'b1;
    endfunction

    task automatic add(input uop_t u, input int n, input blk_t e0, input blk_t e1);
        vec_t x;
        x.u = u; x.n = n; x.e0 = e0; x.e1 = e1;
        tbl.push_back(x);
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", nm, got, req);
        end
    endtask

    task automatic send(input uop_t u);
        int w;
        valid_i = 1'b1; itype_i = u.itype; iaddr_i = u.iaddr; iretire_i = u.ret;
        ilastsize_i = u.ls; priv_i = u.priv; cause_i = u.cause; tval_i = u.tval;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!ready_o && w < 200);
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL send_accept got ready_o=0 after %0d cycles required ready_o=1 (iaddr %h)", w, u.iaddr);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic drain(input string nm);
        int w;
        w = 0;
        while ((exp_q.size() != 0 || valid_o) && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        check(nm, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic expect_blk(input blk_t b);
        exp_q.push_back(b);
    endtask

    always @(negedge clk) begin
        if (rst_n && valid_o && ready_i) begin
            mon_g = B(itype_o, iaddr_o, iretire_o, ilastsize_o, priv_o, cause_o, tval_o);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL blk_unexpected got t=%0d a=%h r=%0d required no block", mon_g.itype, mon_g.iaddr, mon_g.iretire);
            end else begin
                mon_e = exp_q.pop_front();
                if (!blk_match(mon_g, mon_e)) begin
                    errors++;
                    $display("FAIL blk got t=%0d a=%h r=%0d ls=%0d p=%0d c=%0d v=%h required t=%0d a=%h r=%0d ls=%0d p=%0d c=%0d v=%h",
                             mon_g.itype, mon_g.iaddr, mon_g.iretire, mon_g.ls, mon_g.priv, mon_g.cause, mon_g.tval,
                             mon_e.itype, mon_e.iaddr, mon_e.iretire, mon_e.ls, mon_e.priv, mon_e.cause, mon_e.tval);
                end
            end
        end
    end

    initial begin
        blk_t nb;
        bit   seen;
        int   cyc;
        nb = '0;
        rst_n = 1'b0; ready_i = 1'b1; valid_i = 1'b0; itype_i = '0; iaddr_i = '0;
        iretire_i = 1'b1; ilastsize_i = '0; priv_i = '0; cause_i = '0; tval_i = '0;

        // Stream of uops and the blocks each one releases (close-before first).
        add(U(STD,  32'h100, 1, 1, 3, 0, 0), 0, nb, nb);
        add(U(STD,  32'h104, 1, 1, 3, 0, 0), 0, nb, nb);
        add(U(STD,  32'h108, 1, 1, 3, 0, 0), 0, nb, nb);
        add(U(TB,   32'h10C, 1, 1, 3, 0, 0), 1, B(TB, 32'h100, 8, 1, 3, 0, 0), nb);
        add(U(STD,  32'h200, 1, 1, 3, 0, 0), 0, nb, nb);
        add(U(STD,  32'h204, 1, 1, 0, 0, 0), 1, B(STD, 32'h200, 2, 1, 3, 0, 0), nb);
        add(U(NTB,  32'h208, 1, 1, 0, 0, 0), 1, B(NTB, 32'h204, 4, 1, 0, 0, 0), nb);
        add(U(UJ,   32'h500, 1, 0, 1, 0, 0), 1, B(UJ, 32'h500, 1, 0, 1, 0, 0), nb);
        add(U(STD,  32'h600, 1, 1, 1, 0, 0), 0, nb, nb);
        add(U(STD,  32'h700, 1, 1, 1, 0, 0), 1, B(STD, 32'h600, 2, 1, 1, 0, 0), nb);
        add(U(ERET, 32'h800, 1, 1, 1, 0, 0), 2, B(STD, 32'h700, 2, 1, 1, 0, 0), B(ERET, 32'h800, 2, 1, 1, 0, 0));
        add(U(INT,  32'h900, 0, 1, 3, 7, 32'h1234), 1, B(INT, 32'h900, 0, 0, 3, 7, 32'h1234), nb);
        for (int k = 0; k < 7; k++)
            add(U(STD, 32'(k * 4), 1, 1, 0, 0, 0), 0, nb, nb);
        add(U(STD,  32'h1C, 1, 1, 0, 0, 0), 1, B(STD, 32'h0, 14, 1, 0, 0, 0), nb);
        add(U(TB,   32'h1000, 1, 1, 0, 0, 0), 2, B(STD, 32'h1C, 2, 1, 0, 0, 0), B(TB, 32'h1000, 2, 1, 0, 0, 0));
        add(U(STD,  32'h40, 1, 2, 2, 0, 0), 0, nb, nb);
        add(U(STD,  32'h48, 1, 2, 2, 0, 0), 0, nb, nb);
        add(U(STD,  32'h50, 1, 2, 2, 0, 0), 0, nb, nb);
        add(U(STD,  32'h58, 1, 1, 2, 0, 0), 0, nb, nb);
        add(U(NTB,  32'h5C, 1, 0, 2, 0, 0), 1, B(NTB, 32'h40, 15, 0, 2, 0, 0), nb);
        add(U(STD,  32'hA00, 1, 1, 1, 0, 0), 0, nb, nb);
        add(U(EXC,  32'hA04, 0, 1, 1, 3, 32'hBEEF), 2, B(STD, 32'hA00, 2, 1, 1, 0, 0), B(EXC, 32'hA04, 0, 0, 1, 3, 32'hBEEF));
        add(U(STD,  32'hB00, 1, 1, 0, 0, 0), 0, nb, nb);
        add(U(EXC,  32'hB04, 1, 1, 0, 2, 32'h55), 1, B(EXC, 32'hB00, 4, 1, 0, 2, 32'h55), nb);

        #12;
        check("reset_outputs", 64'({valid_o, itype_o, iaddr_o, iretire_o, priv_o}), 64'd0);
        check("reset_ready", 64'(ready_o), 64'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].n > 0) expect_blk(tbl[i].e0);
            if (tbl[i].n > 1) expect_blk(tbl[i].e1);
            send(tbl[i].u);
        end
        drain("table_drain");

        // Stalled output: the STD block must hold while the trap block waits.
        ready_i = 1'b0;
        expect_blk(B(STD, 32'h300, 4, 1, 0, 0, 0));
        expect_blk(B(EXC, 32'h308, 0, 0, 0, 2, 32'hBAD));
        send(U(STD, 32'h300, 1, 1, 0, 0, 0));
        send(U(STD, 32'h304, 1, 1, 0, 0, 0));
        send(U(EXC, 32'h308, 0, 1, 0, 2, 32'hBAD));
        for (int k = 0; k < 5; k++) begin
            check("stall_hold", 64'({ready_o, valid_o, itype_o, iaddr_o, iretire_o}),
                  64'({1'b0, 1'b1, STD, 32'h300, 4'd4}));
            @(posedge clk);
            #1;
        end
        ready_i = 1'b1;
        drain("stall_drain");

        // Idle behaviour of a lone open block.
        send(U(STD, 32'h400, 1, 1, 0, 0, 0));
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            seen = valid_o;
        end
`ifdef MURE_BLOCK_TIMEOUT_EN
        expect_blk(B(STD, 32'h400, 2, 1, 0, 0, 0));
        check("timeout_cycle", 64'(cyc), 64'd17);
        expect_blk(B(TB, 32'h404, 2, 1, 0, 0, 0));
`else
        check("no_timeout_flush", 64'(seen), 64'd0);
        expect_blk(B(TB, 32'h400, 4, 1, 0, 0, 0));
`endif
        send(U(TB, 32'h404, 1, 1, 0, 0, 0));
        drain("timeout_drain");

        // Reset with an open block: the accumulator must be forgotten.
        send(U(STD, 32'hC00, 1, 1, 0, 0, 0));
        #2 rst_n = 1'b0;
        #1 check("rst_open_now", 64'({valid_o, ready_o}), 64'b01);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (valid_o) seen = 1'b1;
        end
        check("rst_open_quiet", 64'(seen), 64'd0);
        expect_blk(B(TB, 32'hC04, 2, 1, 0, 0, 0));
        send(U(TB, 32'hC04, 1, 1, 0, 0, 0));
        drain("rst_open_drain");

        // Reset while a block sits on the stalled output.
        ready_i = 1'b0;
        send(U(UJ, 32'hD00, 1, 1, 2, 0, 0));
        check("rst_vld_pre", 64'({valid_o, iaddr_o}), 64'({1'b1, 32'hD00}));
        #2 rst_n = 1'b0;
        #1 check("rst_vld_now", 64'({valid_o, itype_o, iaddr_o, iretire_o, priv_o}), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (valid_o) seen = 1'b1;
        end
        check("rst_vld_quiet", 64'(seen), 64'd0);
        check("final_queue", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
